window_array: RTL and testbench
===============================

// Module: window_array
// PURPOSE
//  Runtime-programmable N-window hit detector for the gfx pixel pipeline; successor to fixed-parameter window.
//  Per pixel coordinate (x,y) reports which windows contain it, highest-priority hit and window-local coords.
//  Window bounds programmed via a config write port into shadow regs, applied atomically at frame start.
//  Sits between the raster timing generator and the layer/sprite fetch + compositor.
// PARAMETERS
//  N_WINDOWS      4     number of windows; index 0 = highest priority
//  COORD_W        16    width of x, y and all bound registers
//  SCREEN_WIDTH   800   active pixels per line (for TB/assert range only)
//  SCREEN_HEIGHT  600   active lines per frame (for TB/assert range only)
// PORTS
//  clk        in   1                    pipeline/config clock
//  rst        in   1                    synchronous, active-high reset
//  pix_valid  in   1                    x/y valid this cycle
//  x          in   COORD_W              pixel column
//  y          in   COORD_W              pixel row
//  cfg_we     in   1                    config write strobe
//  cfg_win    in   $clog2(N_WINDOWS)    window index to write
//  cfg_field  in   3                    0=x_start 1=x_end 2=y_start 3=y_end 4=enable(bit0) 5-7=ignored
//  cfg_data   in   COORD_W              write data
//  out_valid  out  1                    outputs below valid
//  hit_mask   out  N_WINDOWS            bit i = pixel inside active window i
//  hit        out  1                    |hit_mask
//  hit_idx    out  $clog2(N_WINDOWS)    lowest set index of hit_mask; 0 when !hit
//  local_x    out  COORD_W              x - x_start[hit_idx]; 0 when !hit
//  local_y    out  COORD_W              y - y_start[hit_idx]; 0 when !hit
//  border     out  1                    only with WINDOW_BORDER_EN; see CONFIGURATION
// BEHAVIOUR
//  - Inside test per window: enable && x_start<=x<x_end && y_start<=y<y_end; unsigned compares.
//  - end<=start on either axis = empty window, never hits; no error.
//  - 2-stage pipeline, latency 2: S1 registers compare mask + x,y; S2 priority-encodes and subtracts.
//  - out_valid = pix_valid delayed 2; when out_valid=0 all other outputs held at 0.
//  - local_x/local_y subtraction in COORD_W bits; never wraps because hit implies coord>=start.
//  - Shadow regs written 1 cycle after cfg_we; cfg_field 5-7 writes have no effect.
//  - Active regs <= shadow when pix_valid && x==0 && y==0; that pixel already uses the new config.
//  - cfg_we same cycle as frame start: active loads pre-write shadow; the write applies next frame.
//  - No frame-start pixel ever seen: active keeps reset values (all windows disabled).
//  - Reset: shadow+active bounds=0, enables=0; pipeline flushed; all outputs 0 the cycle after rst.
//  - Reset mid-frame: in-flight pixels dropped, out_valid=0 until 2 cycles after first post-reset pix_valid.
//  - Overlapping windows: hit_mask reports all; hit_idx/local_* follow lowest index.
// CONFIGURATION
//  WINDOW_BORDER_EN defined: border=1 when hit and local_x==0 || local_y==0
//   || x==x_end-1 || y==y_end-1 of window hit_idx; same latency, 0 when !out_valid.
//  WINDOW_BORDER_EN undefined: border port and its logic absent; all else identical.
// TESTING
//  1. Reset, full 800x600 scan, no cfg -> out_valid follows pix_valid +2 cycles, hit_mask always 0.
//  2. Win0=(64,128,16,32) enabled, scan frame -> hit exactly 64x16 px; at (64,16) local=(0,0), (127,31) local=(63,15).
//  3. Win0=(0,100,0,100), win1=(50,150,50,150) -> at (75,75) hit_mask=2'b11, hit_idx=0, local=(75,75); at (120,120) hit_idx=1, local=(70,70).
//  4. Move win0 x_start 64->200 mid-frame -> remainder of frame unchanged; next frame (200,16) hits, (64,16) misses.
//  5. Win with x_end=x_start=10, and one with y_end<y_start -> never hit across full frame.
//  6. Assert rst mid-line at (400,300) -> out_valid=0 next cycle, cfg lost, outputs 0 until re-programmed + frame start.

Source files
------------

// File: rtl/window_array.sv
// Runtime-programmable N-window hit detector: shadow config applied at frame start, 2-stage compare/encode pipeline.
// Optional WINDOW_BORDER_EN adds the border output (1 on the outermost pixel ring of the winning window).
module window_array #(
    parameter int N_WINDOWS     = 4,
    parameter int COORD_W       = 16,
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    localparam int IDX_W        = (N_WINDOWS > 1) ? $clog2(N_WINDOWS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_win,
    input  logic [2:0]         cfg_field,
    input  logic [COORD_W-1:0] cfg_data,
    output logic               out_valid,
    output logic [N_WINDOWS-1:0] hit_mask,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx,
    output logic [COORD_W-1:0] local_x,
    output logic [COORD_W-1:0] local_y
`ifdef WINDOW_BORDER_EN
    ,
    output logic               border
`endif
);

    localparam logic [COORD_W-1:0] SCR_W = COORD_W'(SCREEN_WIDTH);
    localparam logic [COORD_W-1:0] SCR_H = COORD_W'(SCREEN_HEIGHT);

    logic [N_WINDOWS-1:0][COORD_W-1:0] xs_sh_q, xs_sh_d, xe_sh_q, xe_sh_d;
    logic [N_WINDOWS-1:0][COORD_W-1:0] ys_sh_q, ys_sh_d, ye_sh_q, ye_sh_d;
    logic [N_WINDOWS-1:0]              en_sh_q, en_sh_d;

    logic [N_WINDOWS-1:0][COORD_W-1:0] xs_ac_q, xs_ac_d, xe_ac_q, xe_ac_d;
    logic [N_WINDOWS-1:0][COORD_W-1:0] ys_ac_q, ys_ac_d, ye_ac_q, ye_ac_d;
    logic [N_WINDOWS-1:0]              en_ac_q, en_ac_d;

    logic                 s1_valid_q, s1_valid_d;
    logic [N_WINDOWS-1:0] s1_mask_q, s1_mask_d;
    logic [COORD_W-1:0]   s1_x_q, s1_x_d, s1_y_q, s1_y_d;

    logic                 out_valid_q, out_valid_d;
    logic [N_WINDOWS-1:0] hit_mask_q, hit_mask_d;
    logic                 hit_q, hit_d;
    logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;
    logic [COORD_W-1:0]   local_x_q, local_x_d, local_y_q, local_y_d;
    logic                 border_q, border_d;

    logic             frame_start;
    logic             hit_c;
    logic [IDX_W-1:0] idx_c;

    assign frame_start = pix_valid && (x == '0) && (y == '0);

    always_comb begin
        xs_sh_d = xs_sh_q;
        xe_sh_d = xe_sh_q;
        ys_sh_d = ys_sh_q;
        ye_sh_d = ye_sh_q;
        en_sh_d = en_sh_q;
        if (cfg_we && (int'(cfg_win) < N_WINDOWS)) begin
            case (cfg_field)
                3'd0:    xs_sh_d[cfg_win] = cfg_data;
                3'd1:    xe_sh_d[cfg_win] = cfg_data;
                3'd2:    ys_sh_d[cfg_win] = cfg_data;
                3'd3:    ye_sh_d[cfg_win] = cfg_data;
                3'd4:    en_sh_d[cfg_win] = cfg_data[0];
                default: ;
            endcase
        end
    end

    // The _d view of the active set is what the frame-start pixel itself compares against.
    always_comb begin
        xs_ac_d = frame_start ? xs_sh_q : xs_ac_q;
        xe_ac_d = frame_start ? xe_sh_q : xe_ac_q;
        ys_ac_d = frame_start ? ys_sh_q : ys_ac_q;
        ye_ac_d = frame_start ? ye_sh_q : ye_ac_q;
        en_ac_d = frame_start ? en_sh_q : en_ac_q;
    end

    always_comb begin
        s1_mask_d = '0;
        for (int i = 0; i < N_WINDOWS; i++) begin
            s1_mask_d[i] = pix_valid && en_ac_d[i]
                        && (x >= xs_ac_d[i]) && (x < xe_ac_d[i])
                        && (y >= ys_ac_d[i]) && (y < ye_ac_d[i]);
        end
        s1_valid_d = pix_valid;
        s1_x_d     = pix_valid ? x : '0;
        s1_y_d     = pix_valid ? y : '0;
    end

    // Active regs only change on a frame-start pixel, so stage 2 sees the same set stage 1 compared with.
    always_comb begin
        idx_c = '0;
        for (int i = N_WINDOWS - 1; i >= 0; i--) begin
            if (s1_mask_q[i]) idx_c = IDX_W'(i);
        end
        hit_c       = |s1_mask_q;
        out_valid_d = s1_valid_q;
        hit_mask_d  = s1_mask_q;
        hit_d       = hit_c;
        hit_idx_d   = idx_c;
        local_x_d   = hit_c ? (s1_x_q - xs_ac_q[idx_c]) : '0;
        local_y_d   = hit_c ? (s1_y_q - ys_ac_q[idx_c]) : '0;
        border_d    = hit_c && ((local_x_d == '0) || (local_y_d == '0)
                    || (s1_x_q == (xe_ac_q[idx_c] - COORD_W'(1)))
                    || (s1_y_q == (ye_ac_q[idx_c] - COORD_W'(1))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xs_sh_q     <= '0;
            xe_sh_q     <= '0;
            ys_sh_q     <= '0;
            ye_sh_q     <= '0;
            en_sh_q     <= '0;
            xs_ac_q     <= '0;
            xe_ac_q     <= '0;
            ys_ac_q     <= '0;
            ye_ac_q     <= '0;
            en_ac_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_mask_q   <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            out_valid_q <= 1'b0;
            hit_mask_q  <= '0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            local_x_q   <= '0;
            local_y_q   <= '0;
            border_q    <= 1'b0;
        end else begin
            assert (!pix_valid || ((x < SCR_W) && (y < SCR_H)));
            xs_sh_q     <= xs_sh_d;
            xe_sh_q     <= xe_sh_d;
            ys_sh_q     <= ys_sh_d;
            ye_sh_q     <= ye_sh_d;
            en_sh_q     <= en_sh_d;
            xs_ac_q     <= xs_ac_d;
            xe_ac_q     <= xe_ac_d;
            ys_ac_q     <= ys_ac_d;
            ye_ac_q     <= ye_ac_d;
            en_ac_q     <= en_ac_d;
            s1_valid_q  <= s1_valid_d;
            s1_mask_q   <= s1_mask_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            out_valid_q <= out_valid_d;
            hit_mask_q  <= hit_mask_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            local_x_q   <= local_x_d;
            local_y_q   <= local_y_d;
            border_q    <= border_d;
        end
    end

    assign out_valid = out_valid_q;
    assign hit_mask  = hit_mask_q;
    assign hit       = hit_q;
    assign hit_idx   = hit_idx_q;
    assign local_x   = local_x_q;
    assign local_y   = local_y_q;

`ifdef WINDOW_BORDER_EN
    assign border = border_q;
`else
    logic unused_border;
    assign unused_border = border_q;
`endif

endmodule

// File: tb/tb_window_array.sv
// Directed bench for window_array: single-pixel probes with hand-computed hit/priority/local results.
module tb_window_array;

    logic        clk;
    logic        rst;
    logic        pix_valid;
    logic [15:0] x, y;
    logic        cfg_we;
    logic [1:0]  cfg_win;
    logic [2:0]  cfg_field;
    logic [15:0] cfg_data;
    logic        out_valid;
    logic [3:0]  hit_mask;
    logic        hit;
    logic [1:0]  hit_idx;
    logic [15:0] local_x, local_y;
`ifdef WINDOW_BORDER_EN
    logic        border;
`endif

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    window_array dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .x         (x),
        .y         (y),
        .cfg_we    (cfg_we),
        .cfg_win   (cfg_win),
        .cfg_field (cfg_field),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .hit_mask  (hit_mask),
        .hit       (hit),
        .hit_idx   (hit_idx),
        .local_x   (local_x),
        .local_y   (local_y)
`ifdef WINDOW_BORDER_EN
        ,
        .border    (border)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] w, input logic [2:0] f, input logic [15:0] d);
        cfg_we = 1'b1; cfg_win = w; cfg_field = f; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic set_win(input logic [1:0] w, input logic [15:0] xs, input logic [15:0] xe,
                           input logic [15:0] ys, input logic [15:0] ye, input logic en);
        cfg(w, 3'd0, xs);
        cfg(w, 3'd1, xe);
        cfg(w, 3'd2, ys);
        cfg(w, 3'd3, ye);
        cfg(w, 3'd4, {15'd0, en});
    endtask

    // One isolated pixel, then check the result two edges later.
    task automatic probe(input logic [15:0] px, input logic [15:0] py, input logic [3:0] em,
                         input logic [1:0] ei, input logic [15:0] elx, input logic [15:0] ely,
                         input string tag);
        x = px; y = py; pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0; x = 16'd0; y = 16'd0;
        tick();
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".mask"},  32'(hit_mask),  32'(em));
        chk({tag, ".hit"},   32'(hit),       32'(|em));
        chk({tag, ".idx"},   32'(hit_idx),   32'(ei));
        chk({tag, ".lx"},    32'(local_x),   32'(elx));
        chk({tag, ".ly"},    32'(local_y),   32'(ely));
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; x = 16'd0; y = 16'd0;
        cfg_we = 1'b0; cfg_win = 2'd0; cfg_field = 3'd0; cfg_data = 16'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.mask",  32'(hit_mask),  32'd0);
        chk("rst.idx",   32'(hit_idx),   32'd0);
        chk("rst.lx",    32'(local_x),   32'd0);

        // latency: two back-to-back pixels
        x = 16'd0; y = 16'd0; pix_valid = 1'b1;
        tick();
        chk("lat.c1.valid", 32'(out_valid), 32'd0);
        x = 16'd1;
        tick();
        chk("lat.c2.valid", 32'(out_valid), 32'd1);
        chk("lat.c2.mask",  32'(hit_mask),  32'd0);
        pix_valid = 1'b0; x = 16'd0;
        tick();
        chk("lat.c3.valid", 32'(out_valid), 32'd1);
        tick();
        chk("lat.c4.valid", 32'(out_valid), 32'd0);
        probe(16'd799, 16'd599, 4'h0, 2'd0, 16'd0, 16'd0, "nocfg.corner");

        // single window, field 5 write must be ignored
        set_win(2'd0, 16'd64, 16'd128, 16'd16, 16'd32, 1'b1);
        cfg(2'd0, 3'd5, 16'hffff);
        probe(16'd64, 16'd16, 4'h0, 2'd0, 16'd0, 16'd0, "w0.pending");
        probe(16'd0, 16'd0, 4'h0, 2'd0, 16'd0, 16'd0, "w0.fs");
        probe(16'd64, 16'd16, 4'h1, 2'd0, 16'd0, 16'd0, "w0.tl");
`ifdef WINDOW_BORDER_EN
        chk("w0.tl.border", 32'(border), 32'd1);
`endif
        probe(16'd100, 16'd20, 4'h1, 2'd0, 16'd36, 16'd4, "w0.mid");
`ifdef WINDOW_BORDER_EN
        chk("w0.mid.border", 32'(border), 32'd0);
`endif
        probe(16'd127, 16'd31, 4'h1, 2'd0, 16'd63, 16'd15, "w0.br");
`ifdef WINDOW_BORDER_EN
        chk("w0.br.border", 32'(border), 32'd1);
`endif
        probe(16'd128, 16'd16, 4'h0, 2'd0, 16'd0, 16'd0, "w0.xend");
        probe(16'd63,  16'd16, 4'h0, 2'd0, 16'd0, 16'd0, "w0.xlo");
        probe(16'd64,  16'd32, 4'h0, 2'd0, 16'd0, 16'd0, "w0.yend");
        probe(16'd100, 16'd15, 4'h0, 2'd0, 16'd0, 16'd0, "w0.ylo");

        // overlap; frame-start pixel already uses the new config
        set_win(2'd0, 16'd0, 16'd100, 16'd0, 16'd100, 1'b1);
        set_win(2'd1, 16'd50, 16'd150, 16'd50, 16'd150, 1'b1);
        probe(16'd0,   16'd0,   4'h1, 2'd0, 16'd0,  16'd0,  "ov.fs");
        probe(16'd75,  16'd75,  4'h3, 2'd0, 16'd75, 16'd75, "ov.both");
        probe(16'd120, 16'd120, 4'h2, 2'd1, 16'd70, 16'd70, "ov.w1");
        probe(16'd149, 16'd149, 4'h2, 2'd1, 16'd99, 16'd99, "ov.w1edge");
        probe(16'd150, 16'd150, 4'h0, 2'd0, 16'd0,  16'd0,  "ov.out");

        // mid-frame reprogramming is deferred to the next frame start
        set_win(2'd0, 16'd64, 16'd128, 16'd16, 16'd32, 1'b1);
        cfg(2'd1, 3'd4, 16'd0);
        probe(16'd0,  16'd0,  4'h0, 2'd0, 16'd0, 16'd0, "mv.fs1");
        probe(16'd64, 16'd16, 4'h1, 2'd0, 16'd0, 16'd0, "mv.old");
        cfg(2'd0, 3'd0, 16'd200);
        cfg(2'd0, 3'd1, 16'd264);
        probe(16'd64,  16'd16, 4'h1, 2'd0, 16'd0, 16'd0, "mv.still");
        probe(16'd200, 16'd16, 4'h0, 2'd0, 16'd0, 16'd0, "mv.notyet");
        probe(16'd0,   16'd0,  4'h0, 2'd0, 16'd0, 16'd0, "mv.fs2");
        probe(16'd200, 16'd16, 4'h1, 2'd0, 16'd0, 16'd0, "mv.new");
        probe(16'd64,  16'd16, 4'h0, 2'd0, 16'd0, 16'd0, "mv.gone");

        // write coincident with frame start: active takes the pre-write shadow
        x = 16'd0; y = 16'd0; pix_valid = 1'b1;
        cfg_we = 1'b1; cfg_win = 2'd0; cfg_field = 3'd1; cfg_data = 16'd220;
        tick();
        pix_valid = 1'b0; cfg_we = 1'b0;
        tick();
        chk("co.fs.valid", 32'(out_valid), 32'd1);
        chk("co.fs.mask",  32'(hit_mask),  32'd0);
        probe(16'd230, 16'd16, 4'h1, 2'd0, 16'd30, 16'd0, "co.prewrite");
        probe(16'd0,   16'd0,  4'h0, 2'd0, 16'd0,  16'd0, "co.fs2");
        probe(16'd230, 16'd16, 4'h0, 2'd0, 16'd0,  16'd0, "co.applied");
        probe(16'd219, 16'd16, 4'h1, 2'd0, 16'd19, 16'd0, "co.lastcol");

        // empty windows never hit
        cfg(2'd0, 3'd4, 16'd0);
        set_win(2'd2, 16'd10, 16'd10, 16'd0, 16'd600, 1'b1);
        set_win(2'd3, 16'd0, 16'd800, 16'd50, 16'd40, 1'b1);
        probe(16'd0,   16'd0,   4'h0, 2'd0, 16'd0, 16'd0, "em.fs");
        probe(16'd10,  16'd20,  4'h0, 2'd0, 16'd0, 16'd0, "em.xeq");
        probe(16'd10,  16'd45,  4'h0, 2'd0, 16'd0, 16'd0, "em.both");
        probe(16'd5,   16'd45,  4'h0, 2'd0, 16'd0, 16'd0, "em.yinv");
        probe(16'd799, 16'd599, 4'h0, 2'd0, 16'd0, 16'd0, "em.corner");

        // reset mid-line drops in-flight pixels and config
        cfg(2'd2, 3'd4, 16'd0);
        cfg(2'd3, 3'd4, 16'd0);
        set_win(2'd0, 16'd0, 16'd800, 16'd0, 16'd600, 1'b1);
        probe(16'd0, 16'd0, 4'h1, 2'd0, 16'd0, 16'd0, "rs.fs");
        x = 16'd400; y = 16'd300; pix_valid = 1'b1;
        tick();
        x = 16'd401; rst = 1'b1;
        tick();
        chk("rs.c1.valid", 32'(out_valid), 32'd0);
        chk("rs.c1.mask",  32'(hit_mask),  32'd0);
        chk("rs.c1.lx",    32'(local_x),   32'd0);
        rst = 1'b0; pix_valid = 1'b0; x = 16'd0; y = 16'd0;
        tick();
        chk("rs.c2.valid", 32'(out_valid), 32'd0);
        probe(16'd0,   16'd0,   4'h0, 2'd0, 16'd0, 16'd0, "rs.lostfs");
        probe(16'd400, 16'd300, 4'h0, 2'd0, 16'd0, 16'd0, "rs.lost");
        set_win(2'd0, 16'd0, 16'd800, 16'd0, 16'd600, 1'b1);
        probe(16'd400, 16'd300, 4'h0, 2'd0, 16'd0, 16'd0, "rs.noframe");
        probe(16'd0,   16'd0,   4'h1, 2'd0, 16'd0, 16'd0, "rs.refs");
        probe(16'd400, 16'd300, 4'h1, 2'd0, 16'd400, 16'd300, "rs.back");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
